// File: rtl/lenet_vote_if.sv
// ---------------------------------------------------------------------------
// lenet_vote_if
// Groups the LeNet result inputs and the vote outputs of lenet_vote.
//
// Signals
//   lenet_ready   : LeNet done level; every 0->1 transition is one new result
//   lenet_digit   : LeNet classification, valid while lenet_ready is high
//   clear         : synchronous flush of the vote history (active high)
//   voted_digit   : majority digit
//   vote_count    : occurrences of voted_digit in the history
//   voted_valid   : vote_count reached the minimum vote threshold
//   result_strobe : one-cycle pulse when the vote outputs are updated
//   overrun       : sticky flag, a result was dropped
//
// Modports
//   master : result producer / consumer of the vote (drives the inputs)
//   slave  : lenet_vote itself
// ---------------------------------------------------------------------------
interface lenet_vote_if #(
    parameter int WINDOW = 8
);
    localparam int CW = $clog2(WINDOW + 1);

    logic          lenet_ready;
    logic [3:0]    lenet_digit;
    logic          clear;
    logic [3:0]    voted_digit;
    logic [CW-1:0] vote_count;
    logic          voted_valid;
    logic          result_strobe;
    logic          overrun;

    modport master (
        output lenet_ready,
        output lenet_digit,
        output clear,
        input  voted_digit,
        input  vote_count,
        input  voted_valid,
        input  result_strobe,
        input  overrun
    );

    modport slave (
        input  lenet_ready,
        input  lenet_digit,
        input  clear,
        output voted_digit,
        output vote_count,
        output voted_valid,
        output result_strobe,
        output overrun
    );
endinterface

// File: rtl/lenet_vote.sv
// ---------------------------------------------------------------------------
// lenet_vote
// Majority vote over the last WINDOW LeNet digit classifications.
// Each rising edge of lenet_ready (digit 0..9) is pushed into a circular
// history; a per-digit histogram is maintained incrementally and scanned
// digit 0..9 to find the most frequent one (ties go to the lower digit).
// The vote outputs are refreshed 12 cycles after the edge, with a one-cycle
// result_strobe.
//
// Ports
//   clk   : single clock (LeNet clock domain)
//   rst_n : asynchronous active-low reset
//   vif   : lenet_vote_if.slave (see interface header for the signal list)
//
// Parameters
//   WINDOW    : history depth, power of two, 2..16
//   MIN_VOTES : minimum count for voted_valid, 1..WINDOW
//
// Build option
//   LENET_VOTE_HYST_EN : when defined, voted_digit only changes if the scan
//                        winner's count strictly exceeds the count of the
//                        digit currently reported; otherwise it is held.
// ---------------------------------------------------------------------------
module lenet_vote #(
    parameter int WINDOW    = 8,
    parameter int MIN_VOTES = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    lenet_vote_if.slave  vif
);
    localparam int            CW         = $clog2(WINDOW + 1);
    localparam int            PW         = $clog2(WINDOW);
    localparam logic [CW-1:0] FULL_CNT   = CW'(WINDOW);
    localparam logic [CW-1:0] MIN_CNT    = CW'(MIN_VOTES);
    localparam logic [3:0]    LAST_DIGIT = 4'd9;

    typedef enum logic [1:0] {IDLE, UPDATE, SCAN, DONE} state_t;

    state_t        state_reg, state_next;

    logic          ready_q_reg;
    logic          new_result;

    logic [3:0]    cur_digit_reg;
    logic          pend_reg;
    logic [3:0]    pend_digit_reg;
    logic          overrun_reg;

    logic [PW-1:0] ptr_reg;
    logic [CW-1:0] fill_reg;
    logic          full;
    logic [3:0]    buf_mem [WINDOW];
    logic [3:0]    evict_reg;

    logic [CW-1:0] hist [10];

    logic [3:0]    scan_idx_reg;
    logic [3:0]    best_digit_reg;
    logic [CW-1:0] best_cnt_reg;
    logic [CW-1:0] scan_cnt;
    logic [3:0]    cand_digit;
    logic [CW-1:0] cand_cnt;

    logic [3:0]    voted_digit_reg;
    logic [CW-1:0] vote_count_reg;
    logic          voted_valid_reg;
    logic          strobe_reg;

    // Edge against the registered copy; out-of-range digits and edges that
    // coincide with clear are not results at all.
    assign new_result = vif.lenet_ready && !ready_q_reg &&
                        (vif.lenet_digit < 4'd10) && !vif.clear;
    assign full       = (fill_reg == FULL_CNT);

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pend_reg || new_result) state_next = UPDATE;
            UPDATE:  state_next = SCAN;
            SCAN:    if (scan_idx_reg == LAST_DIGIT) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (vif.clear) state_next = IDLE;
    end

    // ------------------------------------------- edge capture and pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q_reg    <= 1'b0;
            cur_digit_reg  <= 4'd0;
            pend_reg       <= 1'b0;
            pend_digit_reg <= 4'd0;
            overrun_reg    <= 1'b0;
        end else begin
            ready_q_reg <= vif.lenet_ready;
            if (vif.clear) begin
                pend_reg    <= 1'b0;
                overrun_reg <= 1'b0;
            end else if (state_reg == IDLE) begin
                if (pend_reg) begin
                    // The pending result goes first; a simultaneous new edge
                    // takes over the (now free) pending slot.
                    cur_digit_reg <= pend_digit_reg;
                    pend_reg      <= new_result;
                    if (new_result) pend_digit_reg <= vif.lenet_digit;
                end else if (new_result) begin
                    cur_digit_reg <= vif.lenet_digit;
                end
            end else if (new_result) begin
                if (pend_reg) begin
                    overrun_reg <= 1'b1;
                end else begin
                    pend_reg       <= 1'b1;
                    pend_digit_reg <= vif.lenet_digit;
                end
            end
        end
    end

    // ------------------------------------------------ history pointer/fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg  <= '0;
            fill_reg <= '0;
        end else if (vif.clear) begin
            ptr_reg  <= '0;
            fill_reg <= '0;
        end else if (state_reg == UPDATE) begin
            ptr_reg <= ptr_reg + 1'b1;    // WINDOW is a power of two: natural wrap
            if (!full) fill_reg <= fill_reg + 1'b1;
        end
    end

    // History RAM. The read is registered every cycle, so the entry about to
    // be overwritten is already in evict_reg when UPDATE runs (the pointer is
    // stable between IDLE and UPDATE).
    always_ff @(posedge clk) begin
        if (state_reg == UPDATE && !vif.clear) buf_mem[ptr_reg] <= cur_digit_reg;
        evict_reg <= buf_mem[ptr_reg];
    end

    // ------------------------------------------------ per-digit histogram
    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_hist
            localparam logic [3:0] DIG = 4'(gi);
            logic          inc, dec;
            logic [CW-1:0] cnt_reg;

            assign inc      = (cur_digit_reg == DIG);
            assign dec      = full && (evict_reg == DIG);
            assign hist[gi] = cnt_reg;

            // new == evicted: +1 and -1 cancel, counter untouched
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (vif.clear) begin
                    cnt_reg <= '0;
                end else if (state_reg == UPDATE) begin
                    if (inc && !dec)      cnt_reg <= cnt_reg + 1'b1;
                    else if (dec && !inc) cnt_reg <= cnt_reg - 1'b1;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------- scan
    always_comb begin
        scan_cnt = '0;
        for (int d = 0; d < 10; d++) begin
            if (scan_idx_reg == 4'(d)) scan_cnt = hist[d];
        end
    end

    // Strict greater-than keeps the lower digit on ties.
    always_comb begin
        cand_digit = best_digit_reg;
        cand_cnt   = best_cnt_reg;
        if (scan_cnt > best_cnt_reg) begin
            cand_digit = scan_idx_reg;
            cand_cnt   = scan_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_idx_reg   <= 4'd0;
            best_digit_reg <= 4'd0;
            best_cnt_reg   <= '0;
        end else if (state_reg == UPDATE) begin
            scan_idx_reg   <= 4'd0;
            best_digit_reg <= 4'd0;
            best_cnt_reg   <= '0;
        end else if (state_reg == SCAN) begin
            scan_idx_reg   <= scan_idx_reg + 4'd1;
            best_digit_reg <= cand_digit;
            best_cnt_reg   <= cand_cnt;
        end
    end

`ifdef LENET_VOTE_HYST_EN
    // Histogram count of the digit currently reported.
    logic [CW-1:0] held_cnt;
    always_comb begin
        held_cnt = '0;
        for (int d = 0; d < 10; d++) begin
            if (voted_digit_reg == 4'(d)) held_cnt = hist[d];
        end
    end
`endif

    // ---------------------------------------------------------- outputs
    // Loaded on the last SCAN cycle so that they (and the strobe) are
    // visible during DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            voted_digit_reg <= 4'd0;
            vote_count_reg  <= '0;
            voted_valid_reg <= 1'b0;
            strobe_reg      <= 1'b0;
        end else if (vif.clear) begin
            vote_count_reg  <= '0;
            voted_valid_reg <= 1'b0;
            strobe_reg      <= 1'b0;
        end else if (state_reg == SCAN && scan_idx_reg == LAST_DIGIT) begin
            strobe_reg <= 1'b1;
`ifdef LENET_VOTE_HYST_EN
            if (cand_cnt > held_cnt) begin
                voted_digit_reg <= cand_digit;
                vote_count_reg  <= cand_cnt;
                voted_valid_reg <= (cand_cnt >= MIN_CNT);
            end else begin
                vote_count_reg  <= held_cnt;
                voted_valid_reg <= (held_cnt >= MIN_CNT);
            end
`else
            voted_digit_reg <= cand_digit;
            vote_count_reg  <= cand_cnt;
            voted_valid_reg <= (cand_cnt >= MIN_CNT);
`endif
        end else begin
            strobe_reg <= 1'b0;
        end
    end

    assign vif.voted_digit   = voted_digit_reg;
    assign vif.vote_count    = vote_count_reg;
    assign vif.voted_valid   = voted_valid_reg;
    assign vif.result_strobe = strobe_reg;
    assign vif.overrun       = overrun_reg;

endmodule
